// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : draw_arbiter
// Description : Round-robin arbiter that shares one VGA plot port between
//               NREQ rectangle-draw requesters. The winning request's
//               rectangle (origin, size, colour) is latched and scanned
//               row-major, one pixel per cycle, followed by a done pulse.
// Ports       : clk, resetn           - clock, async active-low reset
//               req[NREQ]             - per-requester draw request
//               req_x/req_y[NREQ*XW]  - packed origins, requester i at [i*XW +: XW]
//               req_w/req_h[NREQ*SW]  - packed rectangle sizes
//               req_color[NREQ*CW]    - packed fill colours
//               grant/done[NREQ]      - one-hot single-cycle pulses
//               busy                  - high whenever not idle
//               plot_x/plot_y/plot_color/plot_en - pixel write port
// Revision    : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 10,
  parameter int SW   = 6,
  parameter int CW   = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*XW-1:0]   req_y,
  input  logic [NREQ*SW-1:0]   req_w,
  input  logic [NREQ*SW-1:0]   req_h,
  input  logic [NREQ*CW-1:0]   req_color,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [XW-1:0]        plot_x,
  output logic [XW-1:0]        plot_y,
  output logic [CW-1:0]        plot_color,
  output logic                 plot_en
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [XW-1:0]   bx;
  logic [XW-1:0]   by;
  logic [SW-1:0]   w;
  logic [SW-1:0]   h;
  logic [CW-1:0]   col;
  // cx/cy track the pixel currently on the plot outputs
  logic [SW-1:0]   cx;
  logic [SW-1:0]   cy;

  logic            pick_valid;
  logic [IW-1:0]   pick;
  logic            last_col;
  logic            last_pix;
  logic [SW-1:0]   nx;
  logic [SW-1:0]   ny;

  // Round-robin pick: scanning offsets from high to low lets the smallest
  // offset from ptr overwrite any later candidate.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
      end
    end
  end

  // Next scan position; outputs are registered, so the following pixel is
  // computed one cycle ahead of being shown.
  always_comb begin
    last_col = (cx == w - SW'(1));
    last_pix = last_col && (cy == h - SW'(1));
    nx       = last_col ? '0 : cx + SW'(1);
    ny       = last_col ? cy + SW'(1) : cy;
  end

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      win        <= '0;
      bx         <= '0;
      by         <= '0;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      cx         <= '0;
      cy         <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_color <= '0;
      plot_en    <= 1'b0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            win   <= pick;
            bx    <= req_x[pick*XW +: XW];
            by    <= req_y[pick*XW +: XW];
            w     <= req_w[pick*SW +: SW];
            h     <= req_h[pick*SW +: SW];
            col   <= req_color[pick*CW +: CW];
            cx    <= '0;
            cy    <= '0;
            grant <= onehot(pick);
            busy  <= 1'b1;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w == '0 || h == '0) begin
            done  <= onehot(win);
            state <= S_DONE;
          end else begin
            plot_en    <= 1'b1;
            plot_x     <= bx;
            plot_y     <= by;
            plot_color <= col;
            state      <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_pix) begin
            plot_en <= 1'b0;
            done    <= onehot(win);
            state   <= S_DONE;
          end else begin
            cx     <= nx;
            cy     <= ny;
            // Sums wrap modulo 2**XW by truncation.
            plot_x <= bx + XW'(nx);
            plot_y <= by + XW'(ny);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_arbiter
// Description : Scoreboard bench for draw_arbiter. Expected grants, pixels
//               and done pulses are queued when a request is posted and
//               popped by a negedge monitor as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 10;
  localparam int SW   = 6;
  localparam int CW   = 3;

  logic                clk = 1'b0;
  logic                resetn;
  logic [NREQ-1:0]     req;
  logic [NREQ*XW-1:0]  req_x;
  logic [NREQ*XW-1:0]  req_y;
  logic [NREQ*SW-1:0]  req_w;
  logic [NREQ*SW-1:0]  req_h;
  logic [NREQ*CW-1:0]  req_color;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                busy;
  logic [XW-1:0]       plot_x;
  logic [XW-1:0]       plot_y;
  logic [CW-1:0]       plot_color;
  logic                plot_en;

  draw_arbiter #(.NREQ(NREQ), .XW(XW), .SW(SW), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_color(req_color), .grant(grant),
    .done(done), .busy(busy), .plot_x(plot_x), .plot_y(plot_y),
    .plot_color(plot_color), .plot_en(plot_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [NREQ-1:0] q_grant[$];
  logic [NREQ-1:0] q_done[$];
  logic [31:0]     q_pix[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] pix;
    if (grant != '0) begin
      if (q_grant.size() == 0) check("grant_extra", 32'(grant), 32'd0);
      else                     check("grant", 32'(grant), 32'(q_grant.pop_front()));
    end
    if (done != '0) begin
      if (q_done.size() == 0) check("done_extra", 32'(done), 32'd0);
      else                    check("done", 32'(done), 32'(q_done.pop_front()));
    end
    if (plot_en) begin
      pix = 32'({plot_x, plot_y, plot_color});
      if (q_pix.size() == 0) check("pix_extra", pix, 32'hFFFF_FFFF);
      else                   check("pix", pix, q_pix.pop_front());
    end
  end

  task automatic set_req(input int i, input int x, input int y, input int rw, input int rh, input int c);
    req_x[i*XW +: XW]     = XW'(x);
    req_y[i*XW +: XW]     = XW'(y);
    req_w[i*SW +: SW]     = SW'(rw);
    req_h[i*SW +: SW]     = SW'(rh);
    req_color[i*CW +: CW] = CW'(c);
    req[i]                = 1'b1;
  endtask

  task automatic expect_rect(input int i, input int x, input int y, input int rw, input int rh,
                             input int c, input int maxpix, input bit with_done);
    int n;
    n = 0;
    q_grant.push_back(NREQ'(1 << i));
    for (int yy = 0; yy < rh; yy++)
      for (int xx = 0; xx < rw; xx++) begin
        if (n < maxpix) q_pix.push_back(32'({XW'(x + xx), XW'(y + yy), CW'(c)}));
        n++;
      end
    if (with_done) q_done.push_back(NREQ'(1 << i));
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (grant != '0) return;
      if (n > 50) begin
        check("grant_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ngr;
    int last_done;
    int npx;

    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;

    // 1: reset with all requests high
    for (int i = 0; i < NREQ; i++) set_req(i, i * 10, 0, 1, 1, i + 1);
    repeat (3) begin
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_plot_en", 32'(plot_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_plot_x", 32'(plot_x), 32'd0);
    end
    expect_rect(0, 0, 0, 1, 1, 1, 1000, 1'b1);
    resetn = 1'b1;
    wait_grant(n);
    check("t1_latency", 32'(n), 32'd1);
    req = '0;
    wait_idle();

    // 2: basic 2x2 draw from requester 1
    set_req(1, 10, 20, 2, 2, 5);
    expect_rect(1, 10, 20, 2, 2, 5, 1000, 1'b1);
    wait_grant(n);
    check("t2_latency", 32'(n), 32'd1);
    req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t2_plot_en", 32'(plot_en), 32'd1);
    end
    @(negedge clk);
    check("t2_done", 32'(done), 32'b0010);
    check("t2_plot_en_off", 32'(plot_en), 32'd0);
    @(negedge clk);
    check("t2_busy", 32'(busy), 32'd0);

    // 4: zero-width rectangle
    set_req(3, 100, 100, 0, 5, 2);
    expect_rect(3, 100, 100, 0, 5, 2, 1000, 1'b1);
    wait_grant(n);
    req[3] = 1'b0;
    @(negedge clk);
    check("t4_done", 32'(done), 32'b1000);
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd0);

    // 3: two requesters held continuously, pointer now at 0
    set_req(0, 50, 60, 1, 1, 3);
    set_req(2, 70, 80, 1, 1, 4);
    expect_rect(0, 50, 60, 1, 1, 3, 1000, 1'b1);
    expect_rect(2, 70, 80, 1, 1, 4, 1000, 1'b1);
    expect_rect(0, 50, 60, 1, 1, 3, 1000, 1'b1);
    expect_rect(2, 70, 80, 1, 1, 4, 1000, 1'b1);
    ngr = 0;
    last_done = -1;
    for (int c = 0; c < 80 && ngr < 4; c++) begin
      @(negedge clk);
      if (done != '0) last_done = cyc;
      if (grant != '0) begin
        ngr++;
        if (last_done >= 0) check("t3_gap", 32'(cyc - last_done), 32'd2);
        if (ngr == 4) req = '0;
      end
    end
    check("t3_ngrant", 32'(ngr), 32'd4);
    wait_idle();

    // 5: x wrap-around
    set_req(1, 1023, 5, 2, 1, 6);
    expect_rect(1, 1023, 5, 2, 1, 6, 1000, 1'b1);
    wait_grant(n);
    req[1] = 1'b0;
    wait_idle();

    // 6: reset mid-draw, then a full redraw
    set_req(0, 200, 300, 4, 4, 7);
    expect_rect(0, 200, 300, 4, 4, 7, 6, 1'b0);
    wait_grant(n);
    npx = 0;
    for (int c = 0; c < 40 && npx < 6; c++) begin
      @(negedge clk);
      if (plot_en) npx++;
    end
    check("t6_npix", 32'(npx), 32'd6);
    resetn = 1'b0;
    #1;
    check("t6_plot_en", 32'(plot_en), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    expect_rect(0, 200, 300, 4, 4, 7, 1000, 1'b1);
    resetn = 1'b1;
    wait_grant(n);
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);

    check("left_grant", 32'(q_grant.size()), 32'd0);
    check("left_pix", 32'(q_pix.size()), 32'd0);
    check("left_done", 32'(q_done.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
